// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op encodings,
// FSM state encodings and a small op-classification helper.
package hilo_mult_sequencer_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Signed multiplies take operand magnitudes and fix the sign at the end.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD);
  endfunction

endpackage

// File: rtl/hilo_mult_sequencer_mult_shift_add_unit.sv
// Iterative radix-2 shift-add datapath. The low half of the product register
// starts out holding the multiplier and is consumed one bit per Step while the
// partial product grows into the upper half. No control state lives here.
module mult_shift_add_unit
  import hilo_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Load,
  input  logic                 Step,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic [2*WIDTH-1:0]   Product
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;

  // Conditional add of the multiplicand into the upper half, keeping the carry.
  always_comb begin
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  end

  // Load clears the partial product; each Step shifts {carry, product} right.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mcand <= '0;
      prod  <= '0;
    end else if (Load) begin
      mcand <= Multiplicand;
      prod  <= {{WIDTH{1'b0}}, Multiplier};
    end else if (Step) begin
      prod  <= {sum, prod[WIDTH-1:1]};
    end
  end

  assign Product = prod;

endmodule

// File: rtl/hilo_mult_sequencer.sv
// Multi-cycle multiply sequencer and owner of the HI/LO register pair.
// Busy stalls the front of the pipe while a WIDTH-step multiply runs; MTHI/MTLO
// complete in a single cycle without going busy.
// Optional feature: define HILO_MADD_EN to enable MADD/MADDU (accumulate into
// {HI,LO}); without it those ops are ignored like any other illegal op.
module hilo_mult_sequencer
  import hilo_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               sign;
  logic               op_mul;
  logic               op_signed;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] signed_product;
  logic [2*WIDTH-1:0] result;
`ifdef HILO_MADD_EN
  logic               acc;
`endif

  // The most-negative value maps to its unsigned W-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic signed_op);
    return (signed_op && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Decode the request and derive the datapath strobes.
  always_comb begin
`ifdef HILO_MADD_EN
    op_mul = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_MADD) || (Op == OP_MADDU);
`else
    op_mul = (Op == OP_MULT) || (Op == OP_MULTU);
`endif
    op_signed = is_signed_op(Op);
    load      = (state == ST_IDLE) && Start && !Flush && op_mul;
    step      = (state == ST_RUN) && !Flush;
  end

  // Apply the latched sign and, when enabled, accumulate into {HI,LO}.
  always_comb begin
    signed_product = sign ? (~product + {{(2*WIDTH-1){1'b0}}, 1'b1}) : product;
`ifdef HILO_MADD_EN
    result = acc ? ({HI, LO} + signed_product) : signed_product;
`else
    result = signed_product;
`endif
  end

  mult_shift_add_unit #(.WIDTH(WIDTH)) u_datapath (
    .Clk          (Clk),
    .Rst          (Rst),
    .Load         (load),
    .Step         (step),
    .Multiplicand (magnitude(A, op_signed)),
    .Multiplier   (magnitude(B, op_signed)),
    .Product      (product)
  );

  // Sequencer FSM, iteration counter, sign flag, HI/LO and the Done pulse.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      count <= '0;
      sign  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      Done  <= 1'b0;
`ifdef HILO_MADD_EN
      acc   <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !Flush) begin
            if (Op == OP_MTHI) begin
              HI <= A;
            end else if (Op == OP_MTLO) begin
              LO <= A;
            end else if (op_mul) begin
              state <= ST_RUN;
              count <= '0;
              sign  <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef HILO_MADD_EN
              acc   <= Op[2];
`endif
            end
          end
        end
        ST_RUN: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else begin
            count <= count + CW'(1);
            if (count == LAST_STEP) state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          if (!Flush) begin
            {HI, LO} <= result;
            Done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Scoreboard bench for hilo_mult_sequencer: the driver pushes the expected
// {HI,LO} of each multiply, a monitor pops and compares on every Done pulse.
module tb_hilo_mult_sequencer;

  localparam int W = 32;
`ifdef HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic         Flush = 1'b0;
  logic [2:0]   Op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  mon_exp;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 Clk = ~Clk;

  hilo_mult_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact 64-bit product from plain arithmetic on extended operands.
  function automatic logic [63:0] full_product(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] xa, xb;
    if (op == 3'b000 || op == 3'b100) begin
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
    end else begin
      xa = {32'b0, a};
      xb = {32'b0, b};
    end
    return xa * xb;
  endfunction

  function automatic bit is_mul(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (MADD_EN && (op == 3'b100 || op == 3'b101));
  endfunction

  // Count busy cycles up to a bound, then expect the Done pulse.
  task automatic wait_idle(input int exp_cycles);
    int n = 0;
    @(negedge Clk);
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge Clk);
    end
    check("busy_cycles", 64'(n), 64'(exp_cycles));
    check("done_pulse", 64'(Done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; A = $urandom; B = $urandom;
    if (is_mul(op)) begin
      r = full_product(op, a, b);
      if (op[2]) r = r + {m_hi, m_lo};
      {m_hi, m_lo} = r;
      exp_q.push_back(r);
      wait_idle(W + 1);
    end else begin
      if (op == 3'b010) m_hi = a;
      else if (op == 3'b011) m_lo = a;
      @(negedge Clk);
      check("single_cycle_busy", 64'(Busy), 64'd0);
      check("single_cycle_hilo", {HI, LO}, {m_hi, m_lo});
    end
  endtask

  // Start a multiply without waiting for it; used for abort scenarios.
  task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Rst === 1'b0 && Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got Done with HI/LO %h, expected no pulse", {HI, LO});
      end else begin
        mon_exp = exp_q.pop_front();
        check("done_hilo", {HI, LO}, mon_exp);
      end
    end
  end

  initial begin
    logic [31:0] edge_vals[6];
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          n;
    edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

    // Asynchronous reset values
    #2 Rst = 1'b1;
    #1;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // Directed vectors with explicit expected values
    run_op(3'b001, 32'd3, 32'd5);
    check("multu_3x5", {HI, LO}, 64'h0000_0000_0000_000F);
    run_op(3'b000, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg2x3", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000);
    check("mult_minneg", {HI, LO}, 64'h4000_0000_0000_0000);
    run_op(3'b011, 32'h1234, 32'd0);
    check("mtlo", 64'(LO), 64'h1234);

    // Start while busy must be ignored
    start_only(3'b000, 32'd5, 32'd6);
    {m_hi, m_lo} = full_product(3'b000, 32'd5, 32'd6);
    exp_q.push_back({m_hi, m_lo});
    repeat (5) @(negedge Clk);
    Start = 1'b1; Op = 3'b001; A = 32'd100; B = 32'd100;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin n++; @(negedge Clk); end
    repeat (40) @(negedge Clk);
    check("busy_start_ignored", 64'(Busy), 64'd0);
    check("busy_start_hilo", {HI, LO}, 64'd30);

    // Flush during RUN: abort, no write, no Done
    start_only(3'b000, 32'd7, 32'd9);
    repeat (9) @(negedge Clk);
    Flush = 1'b1;
    @(posedge Clk);
    #1 Flush = 1'b0;
    @(negedge Clk);
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_hilo", {HI, LO}, {m_hi, m_lo});
    repeat (40) @(negedge Clk);
    check("flush_still_idle", 64'(Busy), 64'd0);

    // Reset during RUN: immediate return to reset values
    start_only(3'b000, 32'd7, 32'd9);
    repeat (9) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_hilo", {HI, LO}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (40) @(negedge Clk);

    // MADDU accumulates only when the feature is built in
    run_op(3'b011, 32'd10, 32'd0);
    run_op(3'b010, 32'd0, 32'd0);
    run_op(3'b101, 32'd2, 32'd3);
    check("maddu_lo", 64'(LO), MADD_EN ? 64'd16 : 64'd10);

    // Flush in IDLE overrides Start
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1; Op = 3'b011; A = 32'hDEAD;
    @(posedge Clk);
    #1 Start = 1'b0; Flush = 1'b0;
    @(negedge Clk);
    check("idle_flush_lo", 64'(LO), 64'(m_lo));
    check("idle_flush_busy", 64'(Busy), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      run_op(rop, ra, rb);
      check("random_hilo", {HI, LO}, {m_hi, m_lo});
    end

    repeat (5) @(negedge Clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
